// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor split into STAGES equal
// chunks, one chunk of ripple carry per register stage, with a valid/ready
// handshake. A single global enable (adv) advances or holds every stage.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned C = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin;

    // The whole pipe moves only when the output slot is empty or being taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction as A + ~B + 1; a borrow-in removes that +1.
    assign b_eff = sub ? ~b : b;
    assign cin   = ci ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand chunk, carry and valid entering this stage's adder.
        logic [C-1:0]         a_c;
        logic [C-1:0]         b_c;
        logic                 cy_in;
        logic                 vld_in;
        logic [C:0]           add_d;
        // Result chunks 0..k of the operation held in this stage.
        logic [(k+1)*C-1:0]   sum_d;
        logic [(k+1)*C-1:0]   sum_q;
        logic                 cy_q;
        logic                 vld_q;

        if (k == 0) begin : g_head
            assign a_c    = a[C-1:0];
            assign b_c    = b_eff[C-1:0];
            assign cy_in  = cin;
            assign vld_in = in_valid;
            assign sum_d  = add_d[C-1:0];
        end else begin : g_body
            assign a_c    = g_stg[k-1].g_skew.a_q[C-1:0];
            assign b_c    = g_stg[k-1].g_skew.b_q[C-1:0];
            assign cy_in  = g_stg[k-1].cy_q;
            assign vld_in = g_stg[k-1].vld_q;
            // Earlier chunks are deskewed by appending this stage's chunk on top.
            assign sum_d  = {add_d[C-1:0], g_stg[k-1].sum_q};
        end

        assign add_d = {1'b0, a_c} + {1'b0, b_c} + {{C{1'b0}}, cy_in};

        // Stage register: valid bit, inter-stage carry and accumulated sum chunks.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                cy_q  <= add_d[C];
                sum_q <= sum_d;
            end
        end

        // Chunks k+1..STAGES-1 of A and B' still waiting for their stage.
        if (k < STAGES - 1) begin : g_skew
            localparam int unsigned SW = (STAGES - 1 - k) * C;

            logic [SW-1:0] a_d;
            logic [SW-1:0] b_d;
            logic [SW-1:0] a_q;
            logic [SW-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = a[WIDTH-1:C];
                assign b_d = b_eff[WIDTH-1:C];
            end else begin : g_src_prev
                assign a_d = g_stg[k-1].g_skew.a_q[(STAGES-k)*C-1:C];
                assign b_d = g_stg[k-1].g_skew.b_q[(STAGES-k)*C-1:C];
            end

            // Skew register: carry the unconsumed operand chunks one stage on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    // Carry into the MSB is a^b^s at that bit; XOR with carry-out gives overflow.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = g_stg[STAGES-1].a_c[C-1] ^ g_stg[STAGES-1].b_c[C-1]
                 ^ g_stg[STAGES-1].add_d[C-1] ^ g_stg[STAGES-1].add_d[C];

    // Overflow flag registered alongside the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = g_stg[STAGES-1].vld_q;
    assign sum       = g_stg[STAGES-1].sum_q;
    assign co        = g_stg[STAGES-1].cy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: directed vector table on a 16/4 instance,
// hand-written stall/reset sequences, and random traffic on a parameter sweep.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic              clk;
    logic              rst_n;
    logic              sw_rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ci;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              co;
    logic              ovf;

    int checks;
    int failures;
    int sw_done;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, co, sum} of A + B' + cin over 17 bits.
    function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [15:0] yy;
        logic [16:0] full;
        logic        o;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, c ^ s};
        o    = (x[15] == yy[15]) && (full[15] != x[15]);
        return {o, full[16], full[15:0]};
    endfunction

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vci;
        logic        vsub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t tbl [10];

    // One isolated operation: checks latency and result.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        a = v.va; b = v.vb; ci = v.vci; sub = v.vsub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(STAGES - 1));
        chk({nm, " result"}, 64'({ovf, co, sum}), 64'({v.eo, v.ec, v.es}));
    endtask

    // ---------------- parameter sweep with random traffic ----------------
    localparam int unsigned SW_W [4] = '{16, 16, 8, 32};
    localparam int unsigned SW_S [4] = '{1, 16, 2, 4};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned W = SW_W[g];
        localparam int unsigned S = SW_S[g];

        logic         in_valid_s;
        logic         in_ready_s;
        logic [W-1:0] a_s;
        logic [W-1:0] b_s;
        logic         ci_s;
        logic         sub_s;
        logic         out_valid_s;
        logic         out_ready_s;
        logic [W-1:0] sum_s;
        logic         co_s;
        logic         ovf_s;

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (in_valid_s),
            .in_ready  (in_ready_s),
            .a         (a_s),
            .b         (b_s),
            .ci        (ci_s),
            .sub       (sub_s),
            .out_valid (out_valid_s),
            .out_ready (out_ready_s),
            .sum       (sum_s),
            .co        (co_s),
            .ovf       (ovf_s)
        );

        function automatic logic [W+1:0] ref_w(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input logic s);
            logic [W-1:0] yy;
            logic [W:0]   full;
            logic         o;
            yy   = s ? ~y : y;
            full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c ^ s};
            o    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
            return {o, full[W], full[W-1:0]};
        endfunction

        initial begin : sweep
            logic [W+1:0] q_exp [$];
            int unsigned  q_acc [$];
            logic [W+1:0] head;
            int unsigned  acc;
            int unsigned  adv_cnt;
            int unsigned  acc_n;
            int unsigned  cyc;
            logic         adv_e;
            in_valid_s = 1'b0; out_ready_s = 1'b0;
            a_s = '0; b_s = '0; ci_s = 1'b0; sub_s = 1'b0;
            adv_cnt = 0; acc_n = 0; cyc = 0;
            wait (sw_rst_n === 1'b1);
            while ((acc_n < 1000 || q_exp.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                out_ready_s = ($urandom_range(3) != 0);
                adv_e = !out_valid_s || out_ready_s;
                if (out_valid_s) begin
                    if (q_exp.size() == 0) begin
                        chk($sformatf("sweep%0d spurious out_valid", g), 64'(1), 64'(0));
                    end else if (out_ready_s) begin
                        head = q_exp.pop_front();
                        acc  = q_acc.pop_front();
                        chk($sformatf("sweep%0d result", g), 64'({ovf_s, co_s, sum_s}), 64'(head));
                        chk($sformatf("sweep%0d latency", g), 64'(adv_cnt - acc), 64'(S));
                    end
                end
                a_s   = W'($urandom);
                b_s   = W'($urandom);
                ci_s  = 1'($urandom);
                sub_s = 1'($urandom);
                in_valid_s = (acc_n < 1000) && ($urandom_range(4) != 0);
                if (in_valid_s && adv_e) begin
                    q_exp.push_back(ref_w(a_s, b_s, ci_s, sub_s));
                    q_acc.push_back(adv_cnt);
                    acc_n++;
                end
                if (adv_e) adv_cnt++;
            end
            in_valid_s = 1'b0;
            chk($sformatf("sweep%0d completed", g), 64'({acc_n, 32'(q_exp.size())}), 64'({32'd1000, 32'd0}));
            sw_done++;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin : main
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic        sci [8];
        logic        ssub [8];
        logic [17:0] sexp [8];
        int          i_in;
        int          i_out;
        int          stall_left;
        int          extra;
        logic        stalled;
        logic        adv_e;

        checks = 0; failures = 0; sw_done = 0;
        rst_n = 1'b0; sw_rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;

        //            a        b        ci    sub   sum      co    ovf
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset state, with out_ready low so in_ready depends on out_valid alone.
        #3;
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset sum", 64'(sum), 64'(0));
        chk("reset co", 64'(co), 64'(0));
        chk("reset ovf", 64'(ovf), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(1));
        #9;
        rst_n = 1'b1; sw_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back stream with a 3-cycle output stall mid-way.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom);
            sci[i] = 1'($urandom); ssub[i] = 1'($urandom);
            sexp[i] = ref16(sa[i], sb[i], sci[i], ssub[i]);
        end
        i_in = 0; i_out = 0; stall_left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 60 && i_out < 8; cyc++) begin
            @(negedge clk);
            if (out_valid && i_out == 3 && !stalled) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                #1;
                chk("stall in_ready", 64'(in_ready), 64'(0));
                chk("stall hold", 64'({out_valid, ovf, co, sum}), 64'({1'b1, sexp[3]}));
            end else begin
                out_ready = 1'b1;
            end
            adv_e = !out_valid || out_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", i_out), 64'({ovf, co, sum}), 64'(sexp[i_out]));
                i_out++;
            end
            if (i_in < 8) begin
                a = sa[i_in]; b = sb[i_in]; ci = sci[i_in]; sub = ssub[i_in];
                in_valid = 1'b1;
                if (adv_e) i_in++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream count", 64'(i_out), 64'(8));
        chk("stream stalled", 64'(stalled), 64'(1));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream duplicates", 64'(extra), 64'(0));

        // Asynchronous reset with operations in flight.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset out_valid", 64'(out_valid), 64'(1));
        chk("pre-reset sum", 64'(sum), 64'(16'h3333));
        #2;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'(0));
        chk("async reset sum", 64'({ovf, co, sum}), 64'(0));
        chk("async reset in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("post-reset stale results", 64'(extra), 64'(0));
        run_vec(tbl[4], "post-reset vec");

        for (int t = 0; t < 50000 && sw_done < 4; t++) @(negedge clk);
        chk("sweep instances finished", 64'(sw_done), 64'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
